// File: rtl/zone_sequencer.sv
// -----------------------------------------------------------------------------
// zone_sequencer
//
// Irrigation zone scheduler feeding a 1-to-6 valve demultiplexer. A start in
// IDLE latches the zone-request mask. Each requested zone is then opened in
// ascending order for ON_CYCLES clocks, with a GAP_CYCLES all-off pause
// between zones, so the demux selector never moves while a valve is energised.
//
// Parameters
//   ON_CYCLES   clocks each zone is held open      (1 .. 2^CNT_W-1)
//   GAP_CYCLES  off-clocks between zones           (1 .. 2^CNT_W-1)
//   CNT_W       width of the duration counter
//
// Ports
//   i_clk          system clock, rising edge
//   i_reset        synchronous active-high reset
//   i_start        begin a run (sampled only in IDLE)
//   i_abort        terminate the run; valves close on the next edge
//   i_zone_enable  bit i requests zone i (latched on an accepted start)
//   o_sel          demux selector, zone i coded i+1, 000 = no zone
//   o_valve_en     demux data input, 1 = selected valve energised
//   o_busy         high in every state except IDLE
//   o_done         one-clock pulse on normal run completion
// -----------------------------------------------------------------------------
module zone_sequencer #(
  parameter int ON_CYCLES  = 16,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic [5:0] i_zone_enable,
  output logic [2:0] o_sel,
  output logic       o_valve_en,
  output logic       o_busy,
  output logic       o_done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WATER,
    ST_GAP,
    ST_DONE
  } state_t;

  // Counter reload values: the counter runs N-1 .. 0, giving N clocks per phase.
  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  state_t           r_state;
  logic [5:0]       r_mask;
  logic [2:0]       r_zone;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_sel;
  logic             r_valve_en;
  logic             r_busy;
  logic             r_done;

  state_t           w_state_nxt;
  logic [5:0]       w_mask_nxt;
  logic [5:0]       w_mask_left;
  logic [2:0]       w_zone_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_sel_nxt;
  logic             w_valve_en_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  // Index of the lowest set bit; only called with a non-zero mask.
  function automatic logic [2:0] lowest_zone(input logic [5:0] m);
    lowest_zone = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (m[i]) lowest_zone = 3'(i);
    end
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_zone_nxt  = r_zone;
    // Saturating decrement: the counter is reloaded on every phase entry and
    // must never wrap past zero.
    w_cnt_nxt   = (r_cnt != '0) ? r_cnt - CNT_W'(1) : r_cnt;
    // Mask with the zone currently watering retired. Since zones are served
    // lowest first, any bit left set is a higher zone still to be watered.
    w_mask_left = r_mask & ~(6'b000001 << r_zone);

    if (r_state != ST_IDLE && i_abort) begin
      w_state_nxt = ST_IDLE;
      w_mask_nxt  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start && !i_abort) begin
            w_mask_nxt = i_zone_enable;
            if (i_zone_enable != '0) begin
              w_state_nxt = ST_WATER;
              w_zone_nxt  = lowest_zone(i_zone_enable);
              w_cnt_nxt   = ON_LOAD;
            end else begin
              w_state_nxt = ST_DONE;
            end
          end
        end
        ST_WATER: begin
          if (r_cnt == '0) begin
            w_mask_nxt = w_mask_left;
            if (w_mask_left != '0) begin
              w_state_nxt = ST_GAP;
              w_cnt_nxt   = GAP_LOAD;
            end else begin
              w_state_nxt = ST_DONE;
            end
          end
        end
        ST_GAP: begin
          if (r_cnt == '0) begin
            w_state_nxt = ST_WATER;
            w_zone_nxt  = lowest_zone(r_mask);
            w_cnt_nxt   = ON_LOAD;
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_mask_nxt  = '0;
        end
      endcase
    end

    // Outputs are decoded from the next state and registered, so they line up
    // with the state they describe and carry no combinational glitches.
    w_sel_nxt      = (w_state_nxt == ST_WATER) ? w_zone_nxt + 3'd1 : 3'd0;
    w_valve_en_nxt = (w_state_nxt == ST_WATER);
    w_busy_nxt     = (w_state_nxt != ST_IDLE);
    w_done_nxt     = (w_state_nxt == ST_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      // NOTE: the mask, zone and counter are reset along with the state so a
      // run can never resume from stale contents after a reset.
      r_state    <= ST_IDLE;
      r_mask     <= '0;
      r_zone     <= '0;
      r_cnt      <= '0;
      r_sel      <= '0;
      r_valve_en <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_state    <= w_state_nxt;
      r_mask     <= w_mask_nxt;
      r_zone     <= w_zone_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sel      <= w_sel_nxt;
      r_valve_en <= w_valve_en_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign o_sel      = r_sel;
  assign o_valve_en = r_valve_en;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

// File: tb/tb_zone_sequencer.sv
// -----------------------------------------------------------------------------
// tb_zone_sequencer
//
// Self-checking bench for zone_sequencer (ON_CYCLES=4, GAP_CYCLES=2). The
// expected output trace of a run is built directly from the watering rules:
// for every requested zone in ascending order, ON clocks open, GAP clocks off
// between zones, one DONE clock, then idle. Abort/reset turn the rest of the
// trace into all-zero outputs.
// -----------------------------------------------------------------------------
module tb_zone_sequencer;

  localparam int ON  = 4;
  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [5:0] zone_enable;
  logic [2:0] o_sel;
  logic       o_valve_en;
  logic       o_busy;
  logic       o_done;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [2:0] sel;
    logic       valve;
    logic       busy;
    logic       done;
  } obs_t;

  obs_t exp_q[$];

  logic [2:0] prev_sel;
  logic       prev_valve;

  zone_sequencer #(
    .ON_CYCLES (ON),
    .GAP_CYCLES(GAP),
    .CNT_W     (8)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_start      (start),
    .i_abort      (abort),
    .i_zone_enable(zone_enable),
    .o_sel        (o_sel),
    .o_valve_en   (o_valve_en),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp_v);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] dut_obs();
    return {2'b00, o_sel, o_valve_en, o_busy, o_done};
  endfunction

  // Expected outputs for cycles 1..N after a start sampled at the end of cycle 0.
  task automatic build_trace(input logic [5:0] m);
    bit first;
    exp_q.delete();
    first = 1'b1;
    for (int z = 0; z < 6; z++) begin
      if (m[z]) begin
        if (!first) repeat (GAP) exp_q.push_back('{sel: 3'd0, valve: 1'b0, busy: 1'b1, done: 1'b0});
        repeat (ON) exp_q.push_back('{sel: 3'(z + 1), valve: 1'b1, busy: 1'b1, done: 1'b0});
        first = 1'b0;
      end
    end
    exp_q.push_back('{sel: 3'd0, valve: 1'b0, busy: 1'b1, done: 1'b1});
    exp_q.push_back('{sel: 3'd0, valve: 1'b0, busy: 1'b0, done: 1'b0});
  endtask

  // One run: start in the current (idle) cycle, then compare every cycle.
  // abort_cyc > 0 asserts abort (or reset) during that cycle.
  task automatic run_seq(input string name, input logic [5:0] m, input int abort_cyc,
                         input bit use_reset, input bit plan_perturb, input bit noise);
    bit   kill;
    obs_t e;
    build_trace(m);
    zone_enable = m;
    start       = 1'b1;
    kill        = 1'b0;
    for (int c = 1; c <= exp_q.size(); c++) begin
      step();
      start = 1'b0;
      abort = 1'b0;
      reset = 1'b0;
      e = kill ? '0 : exp_q[c-1];
      check($sformatf("%s cyc%0d", name, c), dut_obs(), {2'b00, e});
      if (plan_perturb) begin
        if (c == 2) zone_enable = 6'b000000;
        if (c == 3) start = 1'b1;
      end
      if (noise && !kill && c < exp_q.size() - 1) begin
        zone_enable = 6'($urandom);
        start       = 1'($urandom_range(0, 1));
      end
      if (c == abort_cyc) begin
        if (use_reset) reset = 1'b1;
        else           abort = 1'b1;
        kill = 1'b1;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b0;
  endtask

  // Selector must hold while a valve is energised and must name a real zone.
  always @(negedge clk) begin
    if (prev_valve === 1'b1 && o_valve_en === 1'b1)
      check("sel_stable", {5'b0, o_sel}, {5'b0, prev_sel});
    if (o_valve_en === 1'b1)
      check("sel_range", {7'b0, (o_sel >= 3'd1 && o_sel <= 3'd6)}, 8'd1);
    prev_valve <= o_valve_en;
    prev_sel   <= o_sel;
  end

  initial begin
    int         size;
    int         ab;
    logic [5:0] m;

    reset       = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    zone_enable = 6'b000000;
    repeat (2) step();
    check("reset_state", dut_obs(), 8'd0);
    reset = 1'b0;
    step();
    check("idle_after_reset", dut_obs(), 8'd0);

    run_seq("two_zones", 6'b000101, 0, 1'b0, 1'b0, 1'b0);
    run_seq("top_zone", 6'b100000, 0, 1'b0, 1'b0, 1'b0);
    run_seq("empty_mask", 6'b000000, 0, 1'b0, 1'b0, 1'b0);
    run_seq("all_zones_perturbed", 6'b111111, 0, 1'b0, 1'b1, 1'b0);
    run_seq("abort_in_water", 6'b000011, 3, 1'b0, 1'b0, 1'b0);
    run_seq("run_after_abort", 6'b000011, 0, 1'b0, 1'b0, 1'b0);
    run_seq("reset_in_gap", 6'b000110, 5, 1'b1, 1'b0, 1'b0);

    // start and abort together in IDLE: abort wins, nothing starts.
    zone_enable = 6'b111111;
    start       = 1'b1;
    abort       = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("start_abort_idle %0d", k), dut_obs(), 8'd0);
      step();
    end

    for (int r = 0; r < 24; r++) begin
      m = 6'($urandom);
      build_trace(m);
      size = exp_q.size();
      ab   = 0;
      if (size > 3 && $urandom_range(0, 2) == 0) ab = $urandom_range(1, size - 2);
      run_seq($sformatf("rand%0d_m%b_ab%0d", r, m, ab), m, ab, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/zone_sequencer.md
# zone_sequencer

Irrigation zone scheduler that drives the 1-to-6 valve demultiplexer. On `start` it latches a 6-bit zone-request mask, usually from the soil-moisture comparators. It then opens each requested zone in turn, from zone 0 upward. Each zone stays open for `ON_CYCLES` clocks, followed by a `GAP_CYCLES` all-valves-off pause, so the selector never changes while a valve is energised. Its `sel`/`valve_en` outputs connect directly to the demux selector and data input.

## Interface
- `ON_CYCLES`, default 16: clocks each zone valve is held open; legal range 1 to 2^CNT_W-1.
- `GAP_CYCLES`, default 2: off-clocks between consecutive zones; legal range 1 to 2^CNT_W-1.
- `CNT_W`, default 16: width of the internal duration counter.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a watering run; sampled only in IDLE.
- `abort`  in  1  terminate the run; all valves close on the next edge.
- `zone_enable`  in  6  bit i=1 requests watering of zone i; latched on accepted start.
- `sel`  out  3  demux selector: zone i is coded i+1 (001 to 110); 000 = no zone.
- `valve_en`  out  1  demux data input; 1 = selected valve energised.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-clock pulse when a run completes normally.

## Operation
- All outputs are registered. Reset value of every output is 0: `sel`=000, `valve_en`=0, `busy`=0, `done`=0. State resets to IDLE and the latched mask resets to 0.
- States: IDLE, WATER, GAP, DONE.
- IDLE: `start`=1 and `abort`=0 latches `zone_enable` into `mask`.
  - If `mask`≠0: go to WATER on the lowest set bit.
  - If `mask`=0: go to DONE.
- WATER(i): `sel`=i+1, `valve_en`=1, lasting exactly ON_CYCLES clocks. On expiry, clear `mask[i]`.
  - If any higher bit of `mask` remains set: go to GAP.
  - Otherwise: go to DONE.
- GAP: `sel`=000, `valve_en`=0, lasting exactly GAP_CYCLES clocks, then go to WATER on the next set bit.
- DONE: one clock with `done`=1, `busy`=1, `valve_en`=0, `sel`=000, then go to IDLE.
- Zone order is strictly ascending index. Each requested zone is watered exactly once per run.
- `zone_enable` changes after start are ignored until the next accepted start.
- `start` while busy is ignored. It does not restart or queue a run.
- `abort`=1 in WATER, GAP or DONE: next state is IDLE with all outputs 0, `mask` cleared, and no `done` pulse.
- `abort` and `start` together in IDLE: abort wins, no run starts.
- `reset` mid-run behaves like abort. It takes priority over abort and start.
- Invariants:
  - `sel` never changes while `valve_en`=1.
  - `valve_en`=1 implies `sel` is in 001 to 110.
  - At most one zone is open at any time.

## Timing
- Start is sampled at edge 0.
  - Edges 1 to ON_CYCLES: first zone open.
  - Next GAP_CYCLES edges: gap.
  - Each subsequent zone follows the same pattern.
- Total run length for N requested zones: N·ON_CYCLES + (N−1)·GAP_CYCLES clocks, plus 1 DONE clock.
- Start to first `valve_en`=1 is 1 clock. Start with empty mask gives `done`=1 one clock later.
- Abort or reset to `valve_en`=0 is 1 clock.
- `sel` and `valve_en` change on the same edge only when entering WATER from IDLE or GAP, or when leaving WATER.
- Counter: load ON_CYCLES−1 or GAP_CYCLES−1 on state entry, decrement each clock, and transition when it reaches 0. No wrap-around is permitted.

## Test plan
- ON=4, GAP=2, `zone_enable`=000101, start at cycle 0:
  - `sel`=001 with `valve_en`=1 in cycles 1-4.
  - `sel`=000 with `valve_en`=0 in cycles 5-6.
  - `sel`=011 with `valve_en`=1 in cycles 7-10.
  - `done`=1 in cycle 11; `busy`=0 from cycle 12.
- ON=4, `zone_enable`=100000:
  - `sel`=110 with `valve_en`=1 in cycles 1-4.
  - `done` in cycle 5; no GAP entered.
- `zone_enable`=000000 with start: `done`=1 in cycle 1, `valve_en` stays 0, `busy` high for cycle 1 only.
- ON=4, GAP=2, mask 111111:
  - Pulse `start` again at cycle 3: ignored.
  - Change `zone_enable` to 0 at cycle 2: ignored.
  - Expect six zones, `sel` 001 to 110 ascending, `done` at cycle 35.
- ON=4, mask 000011:
  - `abort` at cycle 3 (zone 0 open): cycle 4 has `valve_en`=0, `sel`=000, `busy`=0, and no `done` follows.
  - A new start then runs normally from zone 0.
- Mask 000110, reset asserted in GAP:
  - All outputs are 0 on the next edge.
  - `start`+`abort` together in IDLE: no run begins.
  - Throughout all tests, assert `sel` is stable whenever `valve_en`=1.
